ysyx_23060077_rd_arbiter: RTL and testbench

Read-channel arbiter sharing the core's single AXI4 read port between the Icache refill engine (burst reads) and the LSU (single-beat loads). Sits between `ysyx_23060077_Icache` / LSU and the AXI master interface of the core. It grants one requester at a time, issues the AR transaction, steers R beats back to the owner and releases the bus on the last beat. Round-robin arbitration prevents either side from starving the other.

---
 rtl/ysyx_23060077_rd_arbiter.sv | 153 +++++++++++++++
 tb/tb_ysyx_23060077_rd_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port between Icache refill bursts and LSU loads.
// AR issued the cycle after a request is seen in IDLE; R beats steered combinationally to the owner, no mid-burst pre-emption.
module ysyx_23060077_rd_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,

  input  logic                      icache_r_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] icache_r_addr_i,
  input  logic [AXI_LEN_WIDTH-1:0]  icache_r_len_i,
  output logic                      icache_r_ready_o,
  output logic [DATA_WIDTH-1:0]     icache_r_data_o,
  output logic                      icache_r_last_o,

  input  logic                      lsu_r_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] lsu_r_addr_i,
  input  logic [2:0]                lsu_r_size_i,
  output logic                      lsu_r_ready_o,
  output logic [DATA_WIDTH-1:0]     lsu_r_data_o,
  output logic [1:0]                lsu_r_resp_o,

  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr_o,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen_o,
  output logic [2:0]                axi_arsize_o,
  output logic [1:0]                axi_arburst_o,
  output logic [3:0]                axi_arid_o,

  input  logic                      axi_rvalid_i,
  output logic                      axi_rready_o,
  input  logic [DATA_WIDTH-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  input  logic [3:0]                axi_rid_i,

  output logic                      rd_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [AXI_LEN_WIDTH-1:0] LEN_ONE = AXI_LEN_WIDTH'(1);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_grant;       // 0 = Icache, 1 = LSU
  logic                        r_last_grant;
  logic [AXI_LEN_WIDTH-1:0]    r_cnt;
  logic [AXI_LEN_WIDTH-1:0]    r_arlen;
  logic [2:0]                  r_arsize;
  logic [AXI_ADDR_WIDTH-1:0]   r_araddr;

  logic                        w_any_req;
  logic                        w_pick_lsu;
  logic [3:0]                  w_arid;
  logic                        w_beat;
  logic                        w_id_ok;
  logic                        w_hit;
  logic                        w_done;
  logic                        w_arvalid;
  logic                        w_rready;

  // On a conflict the side that did not win last time goes first.
  assign w_any_req  = icache_r_valid_i | lsu_r_valid_i;
  assign w_pick_lsu = lsu_r_valid_i & (~icache_r_valid_i | ~r_last_grant);

  assign w_arid  = {3'b000, r_grant};
  // A beat arriving while reset is asserted belongs to an abandoned transaction.
  assign w_beat  = (r_state == S_DATA) & axi_rvalid_i & ~reset;
  assign w_id_ok = (axi_rid_i == w_arid);
  assign w_hit   = w_beat & w_id_ok;
  assign w_done  = w_hit & axi_rlast_i;

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        w_arvalid = 1'b1;
        if (axi_arready_i) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_rready = 1'b1;
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
      r_cnt        <= '0;
      r_arlen      <= '0;
      r_arsize     <= 3'b000;
      r_araddr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_pick_lsu;
            r_araddr <= w_pick_lsu ? lsu_r_addr_i : icache_r_addr_i;
            r_arlen  <= w_pick_lsu ? '0 : icache_r_len_i;
            r_arsize <= w_pick_lsu ? lsu_r_size_i : 3'b010;
          end
        end
        S_ADDR: begin
          if (axi_arready_i) r_cnt <= '0;
        end
        S_DATA: begin
          if (w_hit) r_cnt <= r_cnt + LEN_ONE;
          if (w_done) r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

  assign axi_arvalid_o = w_arvalid;
  assign axi_araddr_o  = r_araddr;
  assign axi_arlen_o   = r_arlen;
  assign axi_arsize_o  = r_arsize;
  assign axi_arburst_o = 2'b01;
  assign axi_arid_o    = w_arid;
  assign axi_rready_o  = w_rready;

  assign icache_r_ready_o = w_hit & ~r_grant;
  assign icache_r_last_o  = w_hit & ~r_grant & axi_rlast_i;
  assign icache_r_data_o  = axi_rdata_i;
  assign lsu_r_ready_o    = w_hit & r_grant;
  assign lsu_r_data_o     = axi_rdata_i;
  assign lsu_r_resp_o     = axi_rresp_i;

  // Beat-count errors are only meaningful for beats that belong to this transaction.
  assign rd_err_o = w_beat & ((axi_rresp_i != 2'b00) | ~w_id_ok |
                              (w_id_ok &  axi_rlast_i & (r_cnt != r_arlen)) |
                              (w_id_ok & ~axi_rlast_i & (r_cnt == r_arlen)));

endmodule

// File: tb/tb_ysyx_23060077_rd_arbiter.sv
// Scenario bench for the read arbiter: directed cases plus a randomized pending-request model.
module tb_ysyx_23060077_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        icache_r_valid_i;
  logic [31:0] icache_r_addr_i;
  logic [7:0]  icache_r_len_i;
  logic        icache_r_ready_o;
  logic [31:0] icache_r_data_o;
  logic        icache_r_last_o;
  logic        lsu_r_valid_i;
  logic [31:0] lsu_r_addr_i;
  logic [2:0]  lsu_r_size_i;
  logic        lsu_r_ready_o;
  logic [31:0] lsu_r_data_o;
  logic [1:0]  lsu_r_resp_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic [3:0]  axi_arid_o;
  logic        axi_rvalid_i;
  logic        axi_rready_o;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic [3:0]  axi_rid_i;
  logic        rd_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int m_last   = 0;  // requester served most recently (0 Icache, 1 LSU)

  ysyx_23060077_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .icache_r_valid_i(icache_r_valid_i), .icache_r_addr_i(icache_r_addr_i),
    .icache_r_len_i(icache_r_len_i), .icache_r_ready_o(icache_r_ready_o),
    .icache_r_data_o(icache_r_data_o), .icache_r_last_o(icache_r_last_o),
    .lsu_r_valid_i(lsu_r_valid_i), .lsu_r_addr_i(lsu_r_addr_i),
    .lsu_r_size_i(lsu_r_size_i), .lsu_r_ready_o(lsu_r_ready_o),
    .lsu_r_data_o(lsu_r_data_o), .lsu_r_resp_o(lsu_r_resp_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
    .axi_arid_o(axi_arid_o), .axi_rvalid_i(axi_rvalid_i),
    .axi_rready_o(axi_rready_o), .axi_rdata_i(axi_rdata_i),
    .axi_rresp_i(axi_rresp_i), .axi_rlast_i(axi_rlast_i),
    .axi_rid_i(axi_rid_i), .rd_err_o(rd_err_o)
  );

  always #5 clock = ~clock;

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic int pick(input bit ic, input bit ls);
    if (ic && ls) return (m_last == 1) ? 0 : 1;
    return ls ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    icache_r_valid_i = 1'b0; icache_r_addr_i = '0; icache_r_len_i = '0;
    lsu_r_valid_i = 1'b0; lsu_r_addr_i = '0; lsu_r_size_i = '0;
    axi_arready_i = 1'b0; axi_rvalid_i = 1'b0; axi_rdata_i = '0;
    axi_rresp_i = '0; axi_rlast_i = 1'b0; axi_rid_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_last = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    icache_r_valid_i = 1'b1;
    axi_rvalid_i = 1'b1; axi_rlast_i = 1'b1; axi_rid_i = 4'd0;
    step(); step();
    #1;
    n_checks++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %0h exp 0", axi_arvalid_o); end
    n_checks++; if (axi_rready_o !== 1'b0) begin n_fail++; $display("FAIL reset_rready got %0h exp 0", axi_rready_o); end
    n_checks++; if (icache_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ic_ready got %0h exp 0", icache_r_ready_o); end
    n_checks++; if (lsu_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_lsu_ready got %0h exp 0", lsu_r_ready_o); end
    n_checks++; if (rd_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0h exp 0", rd_err_o); end
    n_checks++; if (icache_r_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_ic_last got %0h exp 0", icache_r_last_o); end
    clear_inputs();
    step();
    reset = 1'b0;
    m_last = 0;
    step();
  endtask

  task automatic test_icache_lone();
    logic [31:0] d;
    icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h3000_0010; icache_r_len_i = 8'd3;
    #1;
    n_checks++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL ic_idle_arvalid got %0h exp 0", axi_arvalid_o); end
    step();
    axi_arready_i = 1'b1;
    #1;
    n_checks++; if (axi_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL ic_arvalid got %0h exp 1", axi_arvalid_o); end
    n_checks++; if (axi_araddr_o !== 32'h3000_0010) begin n_fail++; $display("FAIL ic_araddr got %h exp 30000010", axi_araddr_o); end
    n_checks++; if (axi_arlen_o !== 8'd3) begin n_fail++; $display("FAIL ic_arlen got %0d exp 3", axi_arlen_o); end
    n_checks++; if (axi_arsize_o !== 3'd2) begin n_fail++; $display("FAIL ic_arsize got %0d exp 2", axi_arsize_o); end
    n_checks++; if (axi_arid_o !== 4'd0) begin n_fail++; $display("FAIL ic_arid got %0d exp 0", axi_arid_o); end
    n_checks++; if (axi_arburst_o !== 2'b01) begin n_fail++; $display("FAIL ic_arburst got %0d exp 1", axi_arburst_o); end
    step();
    axi_arready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      axi_rvalid_i = 1'b1; axi_rdata_i = d; axi_rid_i = 4'd0; axi_rresp_i = 2'b00; axi_rlast_i = (i == 3);
      #1;
      n_checks++; if (axi_rready_o !== 1'b1) begin n_fail++; $display("FAIL ic_rready beat %0d got %0h exp 1", i, axi_rready_o); end
      n_checks++; if (icache_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL ic_ready beat %0d got %0h exp 1", i, icache_r_ready_o); end
      n_checks++; if (icache_r_data_o !== d) begin n_fail++; $display("FAIL ic_data beat %0d got %h exp %h", i, icache_r_data_o, d); end
      n_checks++; if (icache_r_last_o !== logic'(i == 3)) begin n_fail++; $display("FAIL ic_last beat %0d got %0h exp %0h", i, icache_r_last_o, (i == 3)); end
      n_checks++; if (lsu_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL ic_lsu_ready beat %0d got %0h exp 0", i, lsu_r_ready_o); end
      n_checks++; if (rd_err_o !== 1'b0) begin n_fail++; $display("FAIL ic_err beat %0d got %0h exp 0", i, rd_err_o); end
      step();
    end
    clear_inputs();
    m_last = 0;
    #1;
    n_checks++; if (axi_rready_o !== 1'b0) begin n_fail++; $display("FAIL ic_end_rready got %0h exp 0", axi_rready_o); end
    step();
    n_checks++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL ic_end_arvalid got %0h exp 0", axi_arvalid_o); end
  endtask

  task automatic test_lsu_lone();
    logic [31:0] d;
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h8000_0004; lsu_r_size_i = 3'd2;
    step();
    for (int k = 0; k < 4; k++) begin
      axi_arready_i = (k == 3);
      #1;
      n_checks++; if (axi_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL lsu_arvalid cyc %0d got %0h exp 1", k, axi_arvalid_o); end
      n_checks++; if (axi_araddr_o !== 32'h8000_0004) begin n_fail++; $display("FAIL lsu_araddr cyc %0d got %h exp 80000004", k, axi_araddr_o); end
      n_checks++; if ({axi_arlen_o, axi_arsize_o, axi_arid_o} !== {8'd0, 3'd2, 4'd1}) begin n_fail++; $display("FAIL lsu_arfields cyc %0d got len %0d size %0d id %0d exp 0 2 1", k, axi_arlen_o, axi_arsize_o, axi_arid_o); end
      step();
    end
    axi_arready_i = 1'b0;
    d = $urandom;
    axi_rvalid_i = 1'b1; axi_rdata_i = d; axi_rid_i = 4'd1; axi_rresp_i = 2'b00; axi_rlast_i = 1'b1;
    #1;
    n_checks++; if (lsu_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL lsu_ready got %0h exp 1", lsu_r_ready_o); end
    n_checks++; if (lsu_r_data_o !== d) begin n_fail++; $display("FAIL lsu_data got %h exp %h", lsu_r_data_o, d); end
    n_checks++; if (lsu_r_resp_o !== 2'b00) begin n_fail++; $display("FAIL lsu_resp got %0d exp 0", lsu_r_resp_o); end
    n_checks++; if (icache_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL lsu_ic_ready got %0h exp 0", icache_r_ready_o); end
    step();
    clear_inputs();
    m_last = 1;
    #1;
    n_checks++; if (axi_rready_o !== 1'b0) begin n_fail++; $display("FAIL lsu_end_rready got %0h exp 0", axi_rready_o); end
  endtask

  task automatic test_conflict();
    int w;
    do_reset();
    for (int g = 0; g < 3; g++) begin
      icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h100; icache_r_len_i = 8'd0;
      lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h200; lsu_r_size_i = 3'd1;
      w = pick(1'b1, 1'b1);
      step();
      axi_arready_i = 1'b1;
      #1;
      n_checks++; if (axi_arid_o !== 4'(w)) begin n_fail++; $display("FAIL conflict_arid grant %0d got %0d exp %0d", g, axi_arid_o, w); end
      n_checks++; if (axi_araddr_o !== (w == 1 ? 32'h200 : 32'h100)) begin n_fail++; $display("FAIL conflict_araddr grant %0d got %h", g, axi_araddr_o); end
      step();
      axi_arready_i = 1'b0;
      axi_rvalid_i = 1'b1; axi_rid_i = 4'(w); axi_rlast_i = 1'b1; axi_rdata_i = $urandom;
      #1;
      n_checks++; if ({icache_r_ready_o, lsu_r_ready_o} !== (w == 1 ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL conflict_owner grant %0d got %b exp owner %0d", g, {icache_r_ready_o, lsu_r_ready_o}, w); end
      step();
      axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
      m_last = w;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_wait_during_burst();
    icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h1000; icache_r_len_i = 8'd3;
    step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h2000; lsu_r_size_i = 3'd0; end
      axi_rvalid_i = 1'b1; axi_rid_i = 4'd0; axi_rlast_i = (i == 3); axi_rdata_i = $urandom;
      #1;
      n_checks++; if (lsu_r_ready_o !== 1'b0 || axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL wait_no_preempt beat %0d got lsu_ready %0h arvalid %0h exp 0 0", i, lsu_r_ready_o, axi_arvalid_o); end
      n_checks++; if (icache_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL wait_ic_ready beat %0d got %0h exp 1", i, icache_r_ready_o); end
      step();
    end
    icache_r_valid_i = 1'b0; axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
    m_last = 0;
    #1;
    n_checks++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL wait_turn_t1 got arvalid %0h exp 0", axi_arvalid_o); end
    step();
    n_checks++; if (axi_arvalid_o !== 1'b1 || axi_arid_o !== 4'd1 || axi_araddr_o !== 32'h2000) begin n_fail++; $display("FAIL wait_turn_t2 got arvalid %0h id %0d addr %h exp 1 1 2000", axi_arvalid_o, axi_arid_o, axi_araddr_o); end
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rid_i = 4'd1; axi_rlast_i = 1'b1;
    #1;
    n_checks++; if (lsu_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL wait_lsu_ready got %0h exp 1", lsu_r_ready_o); end
    step();
    clear_inputs();
    m_last = 1;
    step();
  endtask

  task automatic test_errors();
    // Error response on an LSU load.
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h40; lsu_r_size_i = 3'd2;
    step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rid_i = 4'd1; axi_rlast_i = 1'b1; axi_rresp_i = 2'b10;
    #1;
    n_checks++; if (lsu_r_resp_o !== 2'b10) begin n_fail++; $display("FAIL err_resp got %0d exp 2", lsu_r_resp_o); end
    n_checks++; if (lsu_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_resp_ready got %0h exp 1", lsu_r_ready_o); end
    n_checks++; if (rd_err_o !== 1'b1) begin n_fail++; $display("FAIL err_resp_pulse got %0h exp 1", rd_err_o); end
    step();
    clear_inputs();
    m_last = 1;
    #1;
    n_checks++; if (rd_err_o !== 1'b0 || axi_rready_o !== 1'b0) begin n_fail++; $display("FAIL err_resp_after got err %0h rready %0h exp 0 0", rd_err_o, axi_rready_o); end
    // Foreign ID beat, then early rlast on beat 2 of a 4-beat refill.
    icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h500; icache_r_len_i = 8'd3;
    step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rid_i = 4'd5; axi_rlast_i = 1'b0;
    #1;
    n_checks++; if (rd_err_o !== 1'b1 || icache_r_ready_o !== 1'b0) begin n_fail++; $display("FAIL err_rid got err %0h ready %0h exp 1 0", rd_err_o, icache_r_ready_o); end
    step();
    axi_rid_i = 4'd0;
    #1;
    n_checks++; if (rd_err_o !== 1'b0 || icache_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_beat1 got err %0h ready %0h exp 0 1", rd_err_o, icache_r_ready_o); end
    step();
    axi_rlast_i = 1'b1;
    #1;
    n_checks++; if (rd_err_o !== 1'b1 || icache_r_last_o !== 1'b1) begin n_fail++; $display("FAIL err_early_last got err %0h last %0h exp 1 1", rd_err_o, icache_r_last_o); end
    step();
    clear_inputs();
    m_last = 0;
    #1;
    n_checks++; if (axi_rready_o !== 1'b0 || rd_err_o !== 1'b0) begin n_fail++; $display("FAIL err_early_idle got rready %0h err %0h exp 0 0", axi_rready_o, rd_err_o); end
    // LSU single beat sent without rlast, then a late rlast.
    lsu_r_valid_i = 1'b1; lsu_r_addr_i = 32'h44; lsu_r_size_i = 3'd2;
    step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rid_i = 4'd1; axi_rlast_i = 1'b0;
    #1;
    n_checks++; if (rd_err_o !== 1'b1) begin n_fail++; $display("FAIL err_missing_last got %0h exp 1", rd_err_o); end
    step();
    axi_rlast_i = 1'b1;
    #1;
    n_checks++; if (rd_err_o !== 1'b1) begin n_fail++; $display("FAIL err_late_last got %0h exp 1", rd_err_o); end
    step();
    clear_inputs();
    m_last = 1;
    step();
  endtask

  task automatic test_reset_mid();
    icache_r_valid_i = 1'b1; icache_r_addr_i = 32'h700; icache_r_len_i = 8'd3;
    step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b1; axi_rid_i = 4'd0; axi_rlast_i = 1'b0;
    #1;
    n_checks++; if (icache_r_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_beat0 got %0h exp 1", icache_r_ready_o); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    icache_r_valid_i = 1'b0;
    m_last = 0;
    #1;
    n_checks++; if (axi_rready_o !== 1'b0 || axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got rready %0h arvalid %0h exp 0 0", axi_rready_o, axi_arvalid_o); end
    n_checks++; if (icache_r_ready_o !== 1'b0 || rd_err_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_fwd got ready %0h err %0h exp 0 0", icache_r_ready_o, rd_err_o); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_random();
    bit          pend [2];
    logic [31:0] paddr [2];
    logic [7:0]  plen;
    logic [2:0]  psize;
    logic [31:0] d;
    int w, dly, nb, gap;
    pend[0] = 1'b0; pend[1] = 1'b0;
    plen = '0; psize = '0; paddr[0] = '0; paddr[1] = '0;
    for (int it = 0; it < 60; it++) begin
      if (!pend[0]) begin paddr[0] = $urandom & 32'hFFFF_FFFC; plen = 8'($urandom_range(0, 7)); pend[0] = 1'($urandom_range(0, 1)); end
      if (!pend[1]) begin paddr[1] = $urandom; psize = 3'($urandom_range(0, 2)); pend[1] = 1'($urandom_range(0, 1)); end
      if (!pend[0] && !pend[1]) pend[0] = 1'b1;
      icache_r_valid_i = pend[0]; icache_r_addr_i = paddr[0]; icache_r_len_i = plen;
      lsu_r_valid_i = pend[1]; lsu_r_addr_i = paddr[1]; lsu_r_size_i = psize;
      w = pick(pend[0], pend[1]);
      #1;
      n_checks++; if (axi_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_idle it %0d got arvalid %0h exp 0", it, axi_arvalid_o); end
      step();
      dly = $urandom_range(0, 3);
      for (int k = 0; k <= dly; k++) begin
        axi_arready_i = (k == dly);
        #1;
        n_checks++;
        if (axi_arvalid_o !== 1'b1 || axi_arid_o !== 4'(w) || axi_araddr_o !== paddr[w] ||
            axi_arlen_o !== (w == 1 ? 8'd0 : plen) || axi_arsize_o !== (w == 1 ? psize : 3'd2)) begin
          n_fail++;
          $display("FAIL rnd_ar it %0d got v%0h id%0d a%h l%0d s%0d exp id%0d a%h", it, axi_arvalid_o, axi_arid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, w, paddr[w]);
        end
        step();
      end
      axi_arready_i = 1'b0;
      nb = (w == 1) ? 1 : int'(plen) + 1;
      for (int b = 0; b < nb; b++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          axi_rvalid_i = 1'b0;
          #1;
          n_checks++; if (icache_r_ready_o !== 1'b0 || lsu_r_ready_o !== 1'b0 || axi_rready_o !== 1'b1) begin n_fail++; $display("FAIL rnd_gap it %0d got ic %0h lsu %0h rready %0h exp 0 0 1", it, icache_r_ready_o, lsu_r_ready_o, axi_rready_o); end
          step();
        end
        d = $urandom;
        axi_rvalid_i = 1'b1; axi_rdata_i = d; axi_rid_i = 4'(w); axi_rresp_i = 2'b00; axi_rlast_i = (b == nb - 1);
        #1;
        n_checks++;
        if ({icache_r_ready_o, lsu_r_ready_o} !== (w == 1 ? 2'b01 : 2'b10) || rd_err_o !== 1'b0 ||
            (w == 1 ? lsu_r_data_o : icache_r_data_o) !== d ||
            (w == 0 && icache_r_last_o !== logic'(b == nb - 1))) begin
          n_fail++;
          $display("FAIL rnd_beat it %0d beat %0d got rdy %b err %0h last %0h exp owner %0d", it, b, {icache_r_ready_o, lsu_r_ready_o}, rd_err_o, icache_r_last_o, w);
        end
        step();
      end
      axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
      pend[w] = 1'b0;
      m_last = w;
    end
    clear_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_icache_lone();
    test_lsu_lone();
    test_conflict();
    test_wait_during_burst();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
